// File: rtl/dma_pkg.sv
// Shared types and constants for the SDRAM DMA writer: FSM states,
// DMA_STATUS bit positions and default widths.
package dma_pkg;
  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_CNT_W  = 16;

  localparam int STAT_BUSY_BIT = 16;
  localparam int STAT_PEND_BIT = 17;
  localparam int STAT_OVR_BIT  = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dma_state_e;
endpackage

// File: rtl/dma_cmd_slot.sv
// Single-entry pending command register with a sticky overrun flag.
// A load and a take in the same cycle replace the entry.
module dma_cmd_slot
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              take,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [ADDR_W-1:0] size_in,
  output logic              valid,
  output logic [ADDR_W-1:0] addr_out,
  output logic [ADDR_W-1:0] size_out,
  output logic              overrun
);
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] size_q, size_d;

  always_comb begin
    valid_d = valid_q;
    ovr_d   = ovr_q;
    addr_d  = addr_q;
    size_d  = size_q;
    if (clr) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (take) valid_d = 1'b0;
      if (load) begin
        if (!valid_q || take) begin
          valid_d = 1'b1;
          addr_d  = addr_in;
          size_d  = size_in;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
    end
  end

  assign valid    = valid_q;
  assign overrun  = ovr_q;
  assign addr_out = addr_q;
  assign size_out = size_q;
endmodule

// File: rtl/sdram_dma_writer.sv
// Stream-to-Avalon-MM DMA writer: copies stream beats into consecutive
// SDRAM words of a commanded buffer, one active plus one pending command.
module sdram_dma_writer
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SOFT_CLR,
  input  logic              CMD_START,
  input  logic [ADDR_W-1:0] CMD_ADDRESS,
  input  logic [ADDR_W-1:0] CMD_SIZE,
  input  logic [DATA_W-1:0] ST_DATA,
  input  logic              ST_VALID,
  output logic              ST_READY,
  output logic [ADDR_W-1:0] SDRAM0_ADDRESS,
  output logic [DATA_W-1:0] SDRAM0_WRITEDATA,
  output logic              SDRAM0_WRITE,
  input  logic              SDRAM0_WAITREQUEST,
  output logic [31:0]       DMA_STATUS
);
  // state | meaning
  // IDLE  | no active buffer; waits for a pending command
  // RUN   | turning stream beats into SDRAM writes for the active buffer
  // DONE  | one cycle: bump buffer counter, chain to pending or go idle

  dma_state_e        state_q, state_d;
  logic [1:0]        rst_sync_q, rst_sync_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] size_q, size_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0] accepted_q, accepted_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              slot_valid, slot_take, slot_ovr;
  logic [ADDR_W-1:0] slot_addr, slot_size;
  logic              run_en, accept, st_ready, hs, start_job;

  dma_cmd_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (SOFT_CLR),
    .load     (CMD_START),
    .take     (slot_take),
    .addr_in  (CMD_ADDRESS),
    .size_in  (CMD_SIZE),
    .valid    (slot_valid),
    .addr_out (slot_addr),
    .size_out (slot_size),
    .overrun  (slot_ovr)
  );

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign run_en     = rst_sync_q[1];

  always_comb begin
    accept   = wr_q & ~SDRAM0_WAITREQUEST;
    st_ready = (state_q == ST_RUN) & ~SOFT_CLR & (issued_q != size_q)
             & (~wr_q | ~SDRAM0_WAITREQUEST);
    hs       = ST_VALID & st_ready;

    state_d    = state_q;
    base_d     = base_q;
    size_d     = size_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q & ~accept;
    cnt_d      = cnt_q;
    start_job  = 1'b0;
    slot_take  = 1'b0;

    if (hs) begin
      wr_d     = 1'b1;
      addr_d   = base_q + issued_q;
      wdata_d  = ST_DATA;
      issued_d = issued_q + 1'b1;
    end
    if (accept && state_q == ST_RUN) accepted_d = accepted_q + 1'b1;

    case (state_q)
      // A write left over from a soft clear must drain before a new buffer
      // starts, otherwise its acceptance would count against the new one.
      ST_IDLE: begin
        if (run_en && slot_valid && !wr_q) begin
          start_job = 1'b1;
          state_d   = (slot_size == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accepted_q == size_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (slot_valid) begin
          start_job = 1'b1;
          state_d   = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_job) begin
      slot_take  = 1'b1;
      base_d     = slot_addr;
      size_d     = slot_size;
      issued_d   = '0;
      accepted_d = '0;
    end

    if (SOFT_CLR) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      slot_take = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      rst_sync_q <= 2'b00;
      base_q     <= '0;
      size_q     <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rst_sync_q <= rst_sync_d;
      base_q     <= base_d;
      size_q     <= size_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ST_READY         = st_ready;
  assign SDRAM0_ADDRESS   = addr_q;
  assign SDRAM0_WRITEDATA = wdata_q;
  assign SDRAM0_WRITE     = wr_q;

  always_comb begin
    DMA_STATUS                = '0;
    DMA_STATUS[15:0]          = 16'(cnt_q);
    DMA_STATUS[STAT_BUSY_BIT] = (state_q != ST_IDLE);
    DMA_STATUS[STAT_PEND_BIT] = slot_valid;
    DMA_STATUS[STAT_OVR_BIT]  = slot_ovr;
  end
endmodule

// File: tb/tb_sdram_dma_writer.sv
// Bench for sdram_dma_writer: random stream/stall stimulus checked against a
// queue of expected write addresses and a beat-index data pattern.
module tb_sdram_dma_writer;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  // Narrow buffer counter so the wrap is reached in a few thousand cycles.
  localparam int CNT_W  = 10;
  localparam int CNT_MOD = 1 << CNT_W;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              SOFT_CLR = 1'b0;
  logic              CMD_START = 1'b0;
  logic [ADDR_W-1:0] CMD_ADDRESS = '0;
  logic [ADDR_W-1:0] CMD_SIZE = '0;
  logic [DATA_W-1:0] ST_DATA = '0;
  logic              ST_VALID = 1'b0;
  logic              ST_READY;
  logic [ADDR_W-1:0] SDRAM0_ADDRESS;
  logic [DATA_W-1:0] SDRAM0_WRITEDATA;
  logic              SDRAM0_WRITE;
  logic              SDRAM0_WAITREQUEST = 1'b0;
  logic [31:0]       DMA_STATUS;

  sdram_dma_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK                (CLK),
    .RST_N              (RST_N),
    .SOFT_CLR           (SOFT_CLR),
    .CMD_START          (CMD_START),
    .CMD_ADDRESS        (CMD_ADDRESS),
    .CMD_SIZE           (CMD_SIZE),
    .ST_DATA            (ST_DATA),
    .ST_VALID           (ST_VALID),
    .ST_READY           (ST_READY),
    .SDRAM0_ADDRESS     (SDRAM0_ADDRESS),
    .SDRAM0_WRITEDATA   (SDRAM0_WRITEDATA),
    .SDRAM0_WRITE       (SDRAM0_WRITE),
    .SDRAM0_WAITREQUEST (SDRAM0_WAITREQUEST),
    .DMA_STATUS         (DMA_STATUS)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  logic [ADDR_W-1:0] exp_addr_q[$];
  int exp_done = 0;
  int wr_idx = 0;
  int hs_cnt = 0;
  int cyc = 0;
  int first_acc = -1;
  int last_acc = -1;
  int stall_mode = 0;
  int valid_mode = 0;
  int stall_cnt = 0;
  int drv_last_wr = 0;
  logic [31:0] seed_hi = 32'h0;
  logic prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return {seed_hi ^ kk, kk * 32'd7 + 32'd1, ~kk, 16'hC0DE, kk[15:0]};
  endfunction

  // Monitor: stall stability, stream beat count, write checks against the model.
  always @(negedge CLK) begin
    cyc++;
    if (RST_N) begin
      if (prev_stall) begin
        chk("stall_write", 128'(SDRAM0_WRITE), 128'(1));
        chk("stall_addr", 128'(SDRAM0_ADDRESS), 128'(prev_addr));
        chk("stall_data", SDRAM0_WRITEDATA, prev_data);
      end
      prev_stall = SDRAM0_WRITE && SDRAM0_WAITREQUEST;
      prev_addr  = SDRAM0_ADDRESS;
      prev_data  = SDRAM0_WRITEDATA;
      if (ST_VALID && ST_READY) hs_cnt++;
      if (SDRAM0_WRITE && !SDRAM0_WAITREQUEST) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_write", 128'(SDRAM0_ADDRESS), 128'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("wr_addr", 128'(SDRAM0_ADDRESS), 128'(exp_addr_q.pop_front()));
          chk("wr_data", SDRAM0_WRITEDATA, pat(wr_idx));
        end
        wr_idx++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
    end
  end

  // Stream source and SDRAM slave stall generator.
  always @(posedge CLK) begin
    #1;
    if (stall_mode == 1 && wr_idx != drv_last_wr) stall_cnt = int'($urandom_range(150, 10));
    drv_last_wr = wr_idx;
    if (stall_mode == 2) begin
      SDRAM0_WAITREQUEST = ($urandom_range(3, 0) == 0);
    end else begin
      SDRAM0_WAITREQUEST = (stall_cnt != 0);
      if (stall_cnt != 0) stall_cnt--;
    end
    ST_VALID = (valid_mode == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
    ST_DATA  = pat(hs_cnt);
  end

  task automatic issue_cmd(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] size,
                           input bit accepted);
    @(posedge CLK); #1;
    CMD_START   = 1'b1;
    CMD_ADDRESS = base;
    CMD_SIZE    = size;
    if (accepted) begin
      for (int i = 0; i < int'(size); i++) exp_addr_q.push_back(base + ADDR_W'(i));
      exp_done++;
    end
    @(posedge CLK); #1;
    CMD_START = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge CLK); #1;
      n++;
    end while ((DMA_STATUS[16] || DMA_STATUS[17] || SDRAM0_WRITE || exp_addr_q.size() != 0)
               && n < budget);
    chk({tag, "_timeout"}, 128'(n >= budget), 128'(0));
  endtask

  task automatic wait_free(input int budget);
    int n;
    n = 0;
    @(negedge CLK); #1;
    while (DMA_STATUS[17] && n < budget) begin
      @(negedge CLK); #1;
      n++;
    end
    if (n >= budget) chk("slot_free_timeout", 128'(1), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, hc, n;
    bit drop;
    logic [ADDR_W-1:0] b;
    seed_hi = $urandom;

    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    chk("rst_status", 128'(DMA_STATUS), 128'(0));
    chk("rst_write", 128'(SDRAM0_WRITE), 128'(0));
    chk("rst_addr", 128'(SDRAM0_ADDRESS), 128'(0));
    chk("rst_data", SDRAM0_WRITEDATA, 128'(0));
    chk("rst_ready", 128'(ST_READY), 128'(0));
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (4) @(posedge CLK);

    // 1: long burst, no stalls, one word per clock
    stall_mode = 0; valid_mode = 0;
    w0 = wr_idx; first_acc = -1;
    issue_cmd(28'h100, 28'd972, 1'b1);
    wait_idle("s1", 3000);
    chk("s1_count", 128'(wr_idx - w0), 128'(972));
    chk("s1_b2b", 128'(last_acc - first_acc), 128'(971));
    chk("s1_done", 128'(DMA_STATUS[15:0]), 128'(exp_done % CNT_MOD));
    chk("s1_ovr", 128'(DMA_STATUS[18]), 128'(0));

    // 2: long random stalls after every write, random stream gaps
    stall_mode = 1; valid_mode = 1;
    w0 = wr_idx;
    issue_cmd(ADDR_W'($urandom), 28'd40, 1'b1);
    wait_idle("s2", 8000);
    chk("s2_count", 128'(wr_idx - w0), 128'(40));
    chk("s2_done", 128'(DMA_STATUS[15:0]), 128'(exp_done % CNT_MOD));

    // 3: second command chains, third is dropped
    stall_mode = 0; valid_mode = 0;
    issue_cmd(ADDR_W'($urandom), 28'd200, 1'b1);
    repeat (10) @(posedge CLK);
    issue_cmd(ADDR_W'($urandom), 28'd50, 1'b1);
    issue_cmd(ADDR_W'($urandom), 28'd30, 1'b0);
    @(negedge CLK); #1;
    chk("s3_pending", 128'(DMA_STATUS[17]), 128'(1));
    chk("s3_ovr", 128'(DMA_STATUS[18]), 128'(1));
    chk("s3_busy", 128'(DMA_STATUS[16]), 128'(1));
    drop = 1'b0; n = 0;
    while (exp_addr_q.size() != 0 && n < 5000) begin
      @(negedge CLK); #1;
      n++;
      if (exp_addr_q.size() != 0 && !DMA_STATUS[16]) drop = 1'b1;
    end
    chk("s3_busy_gap", 128'(drop), 128'(0));
    wait_idle("s3", 500);
    chk("s3_done", 128'(DMA_STATUS[15:0]), 128'(exp_done % CNT_MOD));
    chk("s3_ovr_sticky", 128'(DMA_STATUS[18]), 128'(1));

    // 4: address wrap at the top of the word space
    stall_mode = 2; valid_mode = 1;
    w0 = wr_idx;
    issue_cmd(28'hFFFFFF0, 28'd32, 1'b1);
    wait_idle("s4", 1000);
    chk("s4_count", 128'(wr_idx - w0), 128'(32));

    // 5: soft clear in the middle of a stall
    stall_mode = 1; valid_mode = 0;
    w0 = wr_idx;
    issue_cmd(ADDR_W'($urandom), 28'd20, 1'b1);
    n = 0;
    while (!(SDRAM0_WRITE && SDRAM0_WAITREQUEST && stall_cnt > 5 && wr_idx - w0 >= 3)
           && n < 20000) begin
      @(negedge CLK); #1;
      n++;
    end
    chk("s5_find_stall", 128'(n >= 20000), 128'(0));
    @(posedge CLK); #1;
    SOFT_CLR = 1'b1;
    while (exp_addr_q.size() > 1) void'(exp_addr_q.pop_back());
    w0 = wr_idx; hc = hs_cnt;
    @(posedge CLK); #1;
    SOFT_CLR = 1'b0;
    exp_done = 0;
    wait_idle("s5", 500);
    repeat (20) @(negedge CLK);
    #1;
    chk("s5_one_write", 128'(wr_idx - w0), 128'(1));
    chk("s5_no_beats", 128'(hs_cnt - hc), 128'(0));
    chk("s5_status", 128'(DMA_STATUS), 128'(0));
    w0 = wr_idx;
    issue_cmd(ADDR_W'($urandom), 28'd0, 1'b1);
    wait_idle("s5z", 100);
    chk("s5z_done", 128'(DMA_STATUS[15:0]), 128'(exp_done % CNT_MOD));
    chk("s5z_no_write", 128'(wr_idx - w0), 128'(0));
    chk("s5z_hi", 128'(DMA_STATUS[31:16]), 128'(0));

    // 6: buffer counter wrap with chained size-0/1 commands
    stall_mode = 0; valid_mode = 0;
    for (int k = 0; k < CNT_MOD - 1; k++) begin
      wait_free(200);
      issue_cmd(ADDR_W'($urandom), ADDR_W'($urandom_range(1, 0)), 1'b1);
    end
    wait_idle("s6", 500);
    chk("s6_wrap", 128'(DMA_STATUS[15:0]), 128'(exp_done % CNT_MOD));
    for (int k = 0; k < 3; k++) begin
      wait_free(200);
      issue_cmd(ADDR_W'($urandom), ADDR_W'($urandom_range(1, 0)), 1'b1);
    end
    wait_idle("s6b", 500);
    chk("s6_after_wrap", 128'(DMA_STATUS[15:0]), 128'(exp_done % CNT_MOD));
    chk("s6_ovr", 128'(DMA_STATUS[18]), 128'(0));

    // 7: random buffers with random stalls and stream gaps
    stall_mode = 2; valid_mode = 1;
    for (int k = 0; k < 6; k++) begin
      b = ADDR_W'($urandom);
      w0 = wr_idx;
      n = int'($urandom_range(48, 1));
      issue_cmd(b, ADDR_W'(n), 1'b1);
      wait_idle("s7", 2000);
      chk("s7_count", 128'(wr_idx - w0), 128'(n));
    end
    chk("s7_done", 128'(DMA_STATUS[15:0]), 128'(exp_done % CNT_MOD));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
